// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus master.
//
// Sits between a valid/ready command port and an IOBUF driving an open-drain
// pin. It generates reset/presence sequences and 8-slot LSB-first byte
// transfers. All timing comes from a microsecond prescaler derived from the
// system clock.
//
// Ports:
//   clock, reset_n                 system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op                         0 = bus reset/presence, 1 = byte transfer
//   cmd_data[7:0]                  byte to send (0xFF = pure read)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data[7:0]                  bits sampled during the transfer, LSB first
//   rsp_presence                   presence pulse seen after a bus reset
//   pad_i, pad_oen                 IOBUF I (always 0) and OEN (0 = pull low)
//   pad_o                          IOBUF O, asynchronous line readback
module onewire_master #(
  parameter int CLOCK_HZ = 27_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       pad_i,
  output logic       pad_oen,
  input  logic       pad_o
);

  localparam int US_DIV = CLOCK_HZ / 1_000_000;
  localparam int PW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, SLOT_REC, RESP
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre;
  logic [8:0]    us;
  logic          tick;
  logic          timed;
  logic          sync_p0, sync_p1;
  logic [7:0]    tx;
  logic [7:0]    sr;
  logic [2:0]    bitcnt;
  logic          pres;
  logic          sample_now;
  logic          pres_win;

  assign tick  = (pre == PRE_LAST);
  assign timed = (state == RST_LOW) || (state == RST_REL) || (state == SLOT_LOW) ||
                 (state == SLOT_REL) || (state == SLOT_REC);

  // The read point sits 15 us into the slot. A write-0 slot is still low
  // there (us 15 of SLOT_LOW); a write-1 slot has spent 6 us low, so the
  // point lands 9 us into SLOT_REL.
  assign sample_now = (pre == '0) &&
                      (((state == SLOT_LOW) && (us == 9'd15)) ||
                       ((state == SLOT_REL) && tx[0] && (us == 9'd9)));

  assign pres_win = (state == RST_REL) && (us >= 9'd60) && (us <= 9'd240);

  assign cmd_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = sr;
  assign rsp_presence = pres;
  assign pad_i        = 1'b0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (cmd_valid) state_n = cmd_op ? SLOT_LOW : RST_LOW;
      RST_LOW:  if (tick && (us == 9'd479)) state_n = RST_REL;
      RST_REL:  if (tick && (us == 9'd479)) state_n = RESP;
      SLOT_LOW: if (tick && (us == (tx[0] ? 9'd5 : 9'd59))) state_n = SLOT_REL;
      // Release lasts until 70 us after slot start.
      SLOT_REL: if (tick && (us == (tx[0] ? 9'd63 : 9'd9))) state_n = SLOT_REC;
      SLOT_REC: if (tick && (us == 9'd1)) state_n = (bitcnt == 3'd7) ? RESP : SLOT_LOW;
      RESP:     if (rsp_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pad_oen <= 1'b1;
      pre     <= '0;
      us      <= '0;
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      tx      <= '0;
      sr      <= '0;
      bitcnt  <= '0;
      pres    <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer for the asynchronous line.
      sync_p0 <= pad_o;
      sync_p1 <= sync_p0;

      state <= state_n;
      // Registered pad control follows the state being entered, so the line
      // drops on the same edge that accepts the command or starts a slot.
      pad_oen <= !((state_n == RST_LOW) || (state_n == SLOT_LOW));

      if (state_n != state) begin
        pre <= '0;
        us  <= '0;
      end else if (timed) begin
        if (tick) begin
          pre <= '0;
          us  <= us + 9'd1;
        end else begin
          pre <= pre + 1'b1;
        end
      end

      if ((state == IDLE) && cmd_valid) begin
        tx     <= cmd_data;
        sr     <= '0;
        bitcnt <= '0;
        pres   <= 1'b0;
      end

      if (sample_now) sr <= {sync_p1, sr[7:1]};

      if (pres_win && !sync_p1) pres <= 1'b1;

      if ((state == SLOT_REC) && tick && (us == 9'd1) && (bitcnt != 3'd7)) begin
        bitcnt <= bitcnt + 3'd1;
        tx     <= {1'b0, tx[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// Testbench for onewire_master at CLOCK_HZ = 4 MHz (4 cycles per us).
// The bus is a pull-up: the line is low when the master drives or when the
// behavioural slave pulls. The slave reacts to the bus itself: after a long
// reset pulse it answers with presence 100..220 us after release, and in
// byte slots it can hold the line low 6..45 us after the slot's falling edge.
module tb_onewire_master;

  localparam int US = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_presence, pad_i, pad_oen, pad_o;
  logic [7:0] rsp_data;

  logic       slave_low = 1'b0;
  int         slave_mode = 0;      // 0 passive, 1 presence responder, 2 read-slot puller
  logic [7:0] slave_mask = 8'h00;  // slots (by bit index) in which the slave pulls low

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int lo_start[$];
  int lo_width[$];

  onewire_master #(.CLOCK_HZ(4_000_000)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .pad_i        (pad_i),
    .pad_oen      (pad_oen),
    .pad_o        (pad_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign pad_o = (!pad_oen) ? 1'b0 : (slave_low ? 1'b0 : 1'b1);

  // Low-pulse recorder: start cycle and width of every pad_oen low phase.
  logic mon_prev = 1'b1;
  int   mon_w = 0;
  always @(negedge clock) begin
    if (!pad_oen) begin
      if (mon_prev) begin
        lo_start.push_back(cyc);
        mon_w = 0;
      end
      mon_w = mon_w + 1;
    end else if (!mon_prev) begin
      lo_width.push_back(mon_w);
    end
    mon_prev = pad_oen;
  end

  // Behavioural slave.
  int   s_slot_t = 100000;
  int   s_rel_t = 100000;
  int   s_low_run = 0;
  int   s_idx = -1;
  logic s_prev = 1'b1;
  always @(negedge clock) begin
    if (!pad_oen) begin
      if (s_prev) begin
        s_slot_t  = 0;
        s_idx     = s_idx + 1;
        s_low_run = 0;
      end else begin
        s_slot_t = s_slot_t + 1;
      end
      s_low_run = s_low_run + 1;
      s_rel_t   = 100000;
    end else begin
      if (!s_prev && s_low_run >= 1800) s_rel_t = 0;
      else if (s_rel_t < 100000) s_rel_t = s_rel_t + 1;
      if (s_slot_t < 100000) s_slot_t = s_slot_t + 1;
    end
    if (slave_mode == 0) s_idx = -1;
    slave_low = ((slave_mode == 1) && (s_rel_t >= 100*US) && (s_rel_t < 220*US)) ||
                ((slave_mode == 2) && (s_idx >= 0) && (s_idx < 8) &&
                 slave_mask[s_idx[2:0]] && (s_slot_t >= 6*US) && (s_slot_t < 45*US));
    s_prev = pad_oen;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference low-phase width for pulse i of a command.
  function automatic int exp_width(input logic op, input logic [7:0] d, input int i);
    if (!op) return 480 * US;
    return d[i] ? 6 * US : 60 * US;
  endfunction

  task automatic check_pulses(input string tag, input logic op, input logic [7:0] d, input int acc);
    int n;
    n = op ? 8 : 1;
    chk($sformatf("%s pulse count", tag), lo_start.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s start%0d", tag, i),
          (i < lo_start.size()) ? lo_start[i] - acc : -1, 1 + i * 72 * US);
      chk($sformatf("%s width%0d", tag, i),
          (i < lo_width.size()) ? lo_width[i] : -1, exp_width(op, d, i));
    end
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic send(input logic op, input logic [7:0] d, output int acc);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    chk("cmd_ready before accept", cmd_ready, 1);
    acc = cyc;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag, input int acc, input logic op, input logic [7:0] d,
                            input logic [7:0] pull, input logic exp_p, input int hold,
                            input logic q_en, input logic q_op, input logic [7:0] q_d,
                            output int acc2);
    int         n;
    int         pulses;
    int         exp_lat;
    logic [7:0] exp_d;
    exp_lat = op ? (8 * 72 * US + 1) : (960 * US + 1);
    exp_d   = op ? (d & ~pull) : 8'h00;
    n = 0;
    while (!rsp_valid && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("%s rsp_valid", tag), rsp_valid, 1);
    chk($sformatf("%s latency", tag), cyc - acc, exp_lat);
    chk($sformatf("%s rsp_data", tag), rsp_data, exp_d);
    chk($sformatf("%s rsp_presence", tag), rsp_presence, exp_p);
    chk($sformatf("%s cmd_ready in resp", tag), cmd_ready, 0);
    chk($sformatf("%s pad_oen in resp", tag), pad_oen, 1);
    chk($sformatf("%s pad_i", tag), pad_i, 0);
    check_pulses(tag, op, d, acc);
    if (q_en) begin
      cmd_valid = 1'b1;
      cmd_op    = q_op;
      cmd_data  = q_d;
    end
    pulses = lo_start.size();
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk($sformatf("%s hold rsp_valid", tag), rsp_valid, 1);
      chk($sformatf("%s hold rsp_data", tag), rsp_data, exp_d);
      chk($sformatf("%s hold cmd_ready", tag), cmd_ready, 0);
    end
    chk($sformatf("%s no accept while busy", tag), lo_start.size(), pulses);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk($sformatf("%s rsp_valid after hs", tag), rsp_valid, 0);
    chk($sformatf("%s cmd_ready after hs", tag), cmd_ready, 1);
    acc2 = cyc;
    if (q_en) begin
      lo_start.delete();
      lo_width.delete();
      @(negedge clock);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input string tag, input logic op, input logic [7:0] d, input int mode,
                         input logic [7:0] mask, input int hold,
                         input logic q_en, input logic [7:0] q_d);
    int         acc;
    int         acc2;
    int         dummy;
    logic [7:0] pull;
    slave_mode = 0;
    repeat (2) @(negedge clock);
    slave_mode = mode;
    slave_mask = mask;
    pull = (mode == 2) ? mask : 8'h00;
    lo_start.delete();
    lo_width.delete();
    send(op, d, acc);
    finish_rsp(tag, acc, op, d, pull, (!op && mode == 1), hold, q_en, 1'b1, q_d, acc2);
    if (q_en)
      finish_rsp($sformatf("%s queued", tag), acc2, 1'b1, q_d, pull, 1'b0, 0, 1'b0, 1'b0, 8'h00, dummy);
  endtask

  initial begin
    int         acc;
    int         n;
    int         rv_cnt;
    int         lo_cnt;
    logic [7:0] d;
    logic       op;
    int         mode;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset pad_oen", pad_oen, 1);
    chk("reset pad_i", pad_i, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_presence", rsp_presence, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle pad_oen", pad_oen, 1);
    chk("idle cmd_ready", cmd_ready, 1);

    run_cmd("op0 presence", 1'b0, 8'($urandom), 1, 8'h00, 0, 1'b0, 8'h00);
    run_cmd("op0 empty", 1'b0, 8'h00, 0, 8'h00, 0, 1'b0, 8'h00);
    run_cmd("op1 A5", 1'b1, 8'hA5, 0, 8'h00, 0, 1'b0, 8'h00);
    run_cmd("op1 read 3C", 1'b1, 8'hFF, 2, 8'hC3, 0, 1'b0, 8'h00);

    for (int k = 0; k < 6; k++) begin
      op   = (k % 3) != 0;
      d    = 8'($urandom);
      mode = op ? (($urandom % 2 == 0) ? 0 : 2) : int'($urandom % 2);
      run_cmd($sformatf("rand%0d", k), op, d, mode, 8'($urandom), 0, 1'b0, 8'h00);
    end

    run_cmd("backpressure", 1'b1, 8'($urandom), 0, 8'h00, 100, 1'b1, 8'($urandom));

    // Asynchronous reset in the middle of bit 3's low phase.
    slave_mode = 0;
    repeat (2) @(negedge clock);
    lo_start.delete();
    lo_width.delete();
    send(1'b1, 8'($urandom), acc);
    n = 0;
    while (lo_start.size() < 4 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("abort reached bit3", lo_start.size(), 4);
    chk("abort pad low before reset", pad_oen, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort pad_oen immediate", pad_oen, 1);
    chk("abort cmd_ready in reset", cmd_ready, 1);
    chk("abort rsp_valid in reset", rsp_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    rv_cnt = 0;
    lo_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (rsp_valid) rv_cnt++;
      if (!pad_oen) lo_cnt++;
    end
    chk("abort no response", rv_cnt, 0);
    chk("abort no drive", lo_cnt, 0);
    chk("abort cmd_ready after", cmd_ready, 1);
    chk("abort rsp_data cleared", rsp_data, 0);
    run_cmd("after abort", 1'b1, 8'($urandom), 0, 8'h00, 0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
